// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC, one-outstanding imem read, IF/ID register
// with a one-entry skid buffer that absorbs a response arriving during a stall.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_sel,
  input  logic            flush,
  input  logic [XLEN-1:0] target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] ALIGN    = ~(XLEN'(3));
  localparam logic [XLEN-1:0] START_PC = RESET_PC & ALIGN;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] target_al, resp_pc;
  logic            kill, capture;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc, skid_instr;

  // A kill (redirect or squash) overrides stall and any response in flight.
  assign kill      = pc_sel | ~flush;
  assign target_al = target & ALIGN;
  assign resp_pc   = pc - XLEN'(4);
  assign capture   = (state == WAIT) && imem_rvalid && !kill;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      IDLE: begin
        if (kill) begin
          pc_nxt    = target_al;
          state_nxt = REQ;
        end else if (!skid_valid) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (kill) begin
          pc_nxt = target_al;
          if (imem_ready) state_nxt = DISCARD;
        end else if (imem_ready) begin
          pc_nxt    = pc + XLEN'(4);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (kill) begin
          pc_nxt    = target_al;
          state_nxt = imem_rvalid ? REQ : DISCARD;
        end else if (imem_rvalid) begin
          // A word landing in the skid buffer blocks the next request.
          state_nxt = (stall || skid_valid) ? IDLE : REQ;
        end
      end
      DISCARD: begin
        if (kill) pc_nxt = target_al;
        if (imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= START_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // IF/ID drains the skid buffer before taking a fresh response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= NOP;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP;
    end else if (kill) begin
      id_valid   <= 1'b0;
      id_instr   <= NOP;
      skid_valid <= 1'b0;
    end else if (stall) begin
      if (capture) begin
        skid_valid <= 1'b1;
        skid_pc    <= resp_pc;
        skid_instr <= imem_rdata;
      end
    end else if (skid_valid) begin
      id_valid   <= 1'b1;
      id_pc      <= skid_pc;
      id_instr   <= skid_instr;
      skid_valid <= capture;
      if (capture) begin
        skid_pc    <= resp_pc;
        skid_instr <= imem_rdata;
      end
    end else if (capture) begin
      id_valid <= 1'b1;
      id_pc    <= resp_pc;
      id_instr <= imem_rdata;
    end else begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small imem model returns addr|0xA000 after a
// configurable latency; expected PCs and words are hand-derived per edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_sel = 1'b0;
  logic        flush = 1'b1;
  logic [31:0] target = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] exp_pc;
  int          n_valid;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .flush(flush), .target(target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr)
  );

  always #5 clk = ~clk;

  // Memory model shares the fetch unit's reset, so a reset drops its response.
  always @(posedge clk) begin
    if (!rst_n) begin
      imem_rvalid <= 1'b0;
      mem_pend    <= 1'b0;
    end else begin
      imem_rvalid <= 1'b0;
      if (imem_req && imem_ready) begin
        if (mem_lat <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= imem_addr | 32'h0000_A000;
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= mem_lat - 2;
          mem_addr <= imem_addr;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 0) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_addr | 32'h0000_A000;
          mem_pend    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic fl, input logic [31:0] tgt,
                               input logic st);
    pc_sel = sel;
    flush  = fl;
    target = tgt;
    stall  = st;
  endtask

  task automatic checkId(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'd1);
    checkOutput({tag, "_pc"}, id_pc, pc);
    checkOutput({tag, "_instr"}, id_instr, instr);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req"}, 32'(imem_req), 32'd0);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'd0);
    checkOutput({tag, "_pc"}, id_pc, 32'd0);
    checkOutput({tag, "_instr"}, id_instr, NOP);
  endtask

  task automatic waitValid(input string tag, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!id_valid && n < budget);
    checkOutput({tag, "_seen"}, 32'(id_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset and the first three sequential fetches.
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    checkReset("rst");
    rst_n = 1'b1;
    tick();
    checkOutput("first_req", 32'(imem_req), 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    tick();
    checkOutput("first_early", 32'(id_valid), 32'd0);
    tick();
    checkId("fetch0", 32'h0, 32'h0000_A000);
    for (int k = 1; k < 3; k++) begin
      tick();
      checkOutput("bubble", 32'(id_valid), 32'd0);
      tick();
      checkId("seq", 32'(k * 4), 32'h0000_A000 | 32'(k * 4));
    end

    // Stall for three edges while the 0x10 response lands in the skid buffer.
    tick();
    tick();
    checkId("pre_stall", 32'h0C, 32'h0000_A00C);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("stall_pc", id_pc, 32'h0C);
      checkOutput("stall_valid", 32'(id_valid), 32'd1);
      checkOutput("stall_no_req", 32'(imem_req), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    checkId("unstall", 32'h10, 32'h0000_A010);
    checkOutput("unstall_no_req", 32'(imem_req), 32'd0);
    tick();
    checkOutput("resume_req", 32'(imem_req), 32'd1);
    checkOutput("resume_addr", imem_addr, 32'h14);

    // Reset asserted while a response is outstanding.
    tick();
    checkOutput("in_wait", 32'(imem_req), 32'd0);
    rst_n = 1'b0;
    tick();
    checkReset("midrst");
    rst_n = 1'b1;
    tick();
    checkOutput("rel_v1", 32'(id_valid), 32'd0);
    tick();
    checkOutput("rel_v2", 32'(id_valid), 32'd0);
    tick();
    checkId("rel_first", 32'h0, 32'h0000_A000);

    // Taken branch while waiting for 0x0C (response arrives on the kill edge).
    for (int k = 1; k < 3; k++) begin
      tick();
      tick();
      checkId("seq2", 32'(k * 4), 32'h0000_A000 | 32'(k * 4));
    end
    tick();
    applyStimulus(1'b1, 1'b0, 32'h40, 1'b0);
    tick();
    checkOutput("br_valid", 32'(id_valid), 32'd0);
    checkOutput("br_instr", id_instr, NOP);
    checkOutput("br_req", 32'(imem_req), 32'd1);
    checkOutput("br_addr", imem_addr, 32'h40);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    tick();
    checkId("br_target", 32'h40, 32'h0000_A040);

    // Not-taken for 20 edges: ten instructions, PC stepping by 4.
    exp_pc  = 32'h44;
    n_valid = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (id_valid) begin
        checkOutput("nt_pc", id_pc, exp_pc);
        checkOutput("nt_instr", id_instr, exp_pc | 32'h0000_A000);
        exp_pc = exp_pc + 32'd4;
        n_valid++;
      end
    end
    checkOutput("nt_count", 32'(n_valid), 32'd10);

    // Squash without redirect coinciding with rvalid; target low bits ignored.
    tick();
    checkOutput("wait_6c", 32'(imem_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h83, 1'b0);
    tick();
    checkOutput("sq_req", 32'(imem_req), 32'd1);
    checkOutput("sq_addr", imem_addr, 32'h80);
    checkOutput("sq_valid", 32'(id_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    tick();
    checkId("sq_target", 32'h80, 32'h0000_A080);

    // Two-cycle memory: kill before rvalid goes through DISCARD.
    mem_lat = 2;
    tick();
    checkOutput("lat2_wait", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h100, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    checkOutput("disc_req", 32'(imem_req), 32'd0);
    checkOutput("disc_valid", 32'(id_valid), 32'd0);
    tick();
    checkOutput("disc_exit_req", 32'(imem_req), 32'd1);
    checkOutput("disc_exit_addr", imem_addr, 32'h100);
    checkOutput("disc_drop", 32'(id_valid), 32'd0);
    waitValid("disc_first", 6);
    checkId("disc_target", 32'h100, 32'h0000_A100);

    // Unaccepted request retargeted by a kill, then PC wrap-around.
    imem_ready = 1'b0;
    tick();
    checkOutput("nr_req", 32'(imem_req), 32'd1);
    checkOutput("nr_addr", imem_addr, 32'h104);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
    tick();
    checkOutput("nr_kill_req", 32'(imem_req), 32'd1);
    checkOutput("nr_kill_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
    imem_ready = 1'b1;
    mem_lat    = 1;
    tick();
    tick();
    checkId("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
